imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the processor core.
- Receives a byte stream from a host link (UART receiver or testbench), assembles little-endian 32-bit instruction words and writes them into the instruction memory write port.
- Holds the core in reset until a complete, checksum-verified image has been written, then releases it.

Parameters:
- ADDR_WIDTH, 8, instruction memory word-address width; capacity = 2**ADDR_WIDTH words.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write strobe, one-cycle pulse.
- imem_addr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  instruction word for the write.
- core_reset  output  1  reset to the processor core; high until the load succeeds.
- load_done  output  1  image loaded and verified.
- load_error  output  1  load aborted (checksum mismatch or oversize image).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
- Reset values:
  - state=HDR0, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, load_done=0, load_error=0.
  - Internal word count, byte index, word index and checksum all cleared.
- Byte acceptance:
  - A byte is accepted when rx_valid & rx_ready on a clock edge.
  - rx_ready=1 in HDR0, HDR1, DATA and CHK; rx_ready=0 in DONE and ERR.
  - rx_valid may drop at any time; gaps have no effect.
- Stream format:
  - 2-byte word count N, little-endian.
  - Then 4*N data bytes, each word little-endian (first byte is bits [7:0]).
  - Then 1 checksum byte.
- Checksum: 8-bit modular sum of every accepted byte, including the header and the checksum byte itself, must equal 0x00.
- States:
  - HDR0: accept low byte of N -> HDR1.
  - HDR1: accept high byte of N.
    - If N > 2**ADDR_WIDTH -> ERR.
    - Else if N==0 -> CHK.
    - Else -> DATA.
  - DATA: shift bytes into the word assembler. On the 4th byte of a word:
    - next cycle imem_we=1 for exactly one cycle.
    - imem_addr = word index (first word at 0).
    - imem_wdata = assembled word.
    - Word index increments.
    - After word N is accepted -> CHK.
  - CHK: accept checksum byte.
    - If the sum including this byte is 0x00 -> DONE, else -> ERR.
  - DONE: core_reset=0 and load_done=1 from the cycle after the checksum byte is accepted. Held until reset.
  - ERR: load_error=1, core_reset stays 1, no further imem writes. Held until reset.
- Write latency: 1 cycle from acceptance of the 4th byte of a word to the imem_we pulse.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- The final word's imem_we pulse always precedes or coincides with the CHK→DONE transition, so memory is complete when core_reset falls.
- N == 2**ADDR_WIDTH is legal: the final address is all-ones and the word index does not wrap to 0 before CHK.
- Reset asserted mid-load:
  - Next cycle all state and outputs return to reset values.
  - Any pending imem_we is suppressed.
  - A partial word is discarded.
- rx_valid held high in DONE or ERR: ignored, no byte consumed.

Test Plan:
1. Normal load:
   - Stream 02 00 13 00 10 00 93 00 20 00 28.
   - imem_we at addr 0 with 0x00100013, then addr 1 with 0x00200093.
   - core_reset=0 and load_done=1 one cycle after byte 28 is accepted.
2. Bad checksum:
   - Same stream with trailer 29.
   - Both words written, then load_error=1, core_reset stays 1, rx_ready=0, load_done=0.
3. Empty image:
   - Stream 00 00 00.
   - No imem_we pulse; load_done=1, core_reset=0.
4. Oversize image:
   - ADDR_WIDTH=4, stream 11 00 (N=17).
   - load_error=1 one cycle after the second byte; no imem_we; rx_ready=0.
   - Repeat with N=16 and a correct checksum: last write at addr 15, load_done=1.
5. Flow gaps:
   - Test 1 stream with random 0–5 idle cycles of rx_valid=0 between bytes.
   - Identical imem writes and final state as test 1.
6. Reset mid-load:
   - Assert reset after the 5th byte of the test 1 stream.
   - Outputs return to reset values, no write from the partial word.
   - Replaying the full test 1 stream then produces test 1 results from addr 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot loader: assembles a length-prefixed, checksummed little-endian byte stream
// into 32-bit words, writes them to instruction memory and then releases the core.
module imem_loader #(
    parameter int ADDR_WIDTH = 8  // must not exceed 15: the 16-bit word count is narrowed to ADDR_WIDTH+1 bits
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  load_done,
    output logic                  load_error
);

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        DATA = 3'd2,
        CHK  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_WIDTH);

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

    state_t              state_r;
    logic [7:0]          n_lo_r;
    logic [ADDR_WIDTH:0] count_r;
    logic [ADDR_WIDTH:0] word_idx_r;
    logic [1:0]          byte_idx_r;
    logic [23:0]         shift_r;
    logic [7:0]          sum_r;

    logic                accept_s;
    logic [15:0]         n_s;
    logic [7:0]          sum_next_s;
    logic [ADDR_WIDTH:0] word_next_s;

    // Byte handshake, decoded header and running checksum/word index
    always_comb begin
        accept_s    = rx_valid & rx_ready;
        n_s         = {rx_data, n_lo_r};
        sum_next_s  = csum_add(sum_r, rx_data);
        word_next_s = word_idx_r + (ADDR_WIDTH + 1)'(1);
    end

    // Load sequencer with registered handshake, memory-write and core-control outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= HDR0;
            n_lo_r     <= 8'h00;
            count_r    <= '0;
            word_idx_r <= '0;
            byte_idx_r <= 2'd0;
            shift_r    <= 24'h000000;
            sum_r      <= 8'h00;
            rx_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h00000000;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept_s) begin
                sum_r <= sum_next_s;
                case (state_r)
                    HDR0: begin
                        n_lo_r  <= rx_data;
                        state_r <= HDR1;
                    end
                    HDR1: begin
                        if ({1'b0, n_s} > CAPACITY) begin
                            state_r    <= ERR;
                            rx_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else if (n_s == 16'h0000) begin
                            state_r <= CHK;
                        end else begin
                            count_r <= n_s[ADDR_WIDTH:0];
                            state_r <= DATA;
                        end
                    end
                    DATA: begin
                        shift_r    <= {rx_data, shift_r[23:8]};
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx_r[ADDR_WIDTH-1:0];
                            imem_wdata <= {rx_data, shift_r};
                            word_idx_r <= word_next_s;
                            // index is one bit wider so a full-capacity image ends here, not at wrap
                            if (word_next_s == count_r) begin
                                state_r <= CHK;
                            end
                        end
                    end
                    CHK: begin
                        rx_ready <= 1'b0;
                        if (sum_next_s == 8'h00) begin
                            state_r    <= DONE;
                            core_reset <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state_r    <= ERR;
                            load_error <= 1'b1;
                        end
                    end
                    DONE: state_r <= DONE;
                    ERR:  state_r <= ERR;
                    default: begin
                        state_r    <= ERR;
                        rx_ready   <= 1'b0;
                        load_error <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are accepted
// and matched against each imem_we pulse (address, data and one-cycle latency).
module tb_imem_loader;

    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          load_done;
    logic          load_error;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          writes_seen = 0;
    logic [AW-1:0] last_addr;
    logic [31:0] mem_img [16];

    // stream model
    int          pos;
    int          n_hdr;
    logic [7:0]  n_lo;
    logic [31:0] asm_word;
    logic [7:0]  sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // cycle counter used to check write latency
    always @(posedge clock) cyc <= cyc + 1;

    // write monitor: every pulse must match the head of the scoreboard
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
                check("wr_latency", 32'(cyc), 32'(e.due));
            end
            mem_img[imem_addr] <= imem_wdata;
            last_addr <= imem_addr;
            writes_seen <= writes_seen + 1;
        end
    end

    task automatic model_clear();
        pos = 0; n_hdr = 0; n_lo = 8'h00; asm_word = 32'h0; sum = 8'h00;
        exp_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_load_error"}, 32'(load_error), 32'd0);
    endtask

    // reset for one edge; rx_valid is left as the caller set it for that edge
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        rx_valid = 1'b0;
        model_clear();
        writes_seen = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int idx;
        repeat ($urandom_range(gap_max, 0)) @(posedge clock);
        #1;
        check("rx_ready_pre", 32'(rx_ready), 32'd1);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        pos++;
        sum = sum + b;
        if (pos == 1) begin
            n_lo = b;
        end else if (pos == 2) begin
            n_hdr = int'({b, n_lo});
        end else if (n_hdr <= 16 && pos <= 2 + 4 * n_hdr) begin
            idx = pos - 3;
            asm_word = {b, asm_word[31:8]};
            if (idx % 4 == 3) exp_q.push_back('{cyc, AW'(idx / 4), asm_word});
        end
    endtask

    // send all bytes, checking the core is still held before the last one
    task automatic send_stream(input logic [7:0] s[$], input int gap_max);
        for (int i = 0; i < s.size(); i++) begin
            if (i == s.size() - 1) check("core_reset_held", 32'(core_reset), 32'd1);
            send_byte(s[i], gap_max);
        end
    endtask

    task automatic check_final(input string tag, input logic done, input int n_writes);
        check({tag, "_load_done"}, 32'(load_done), 32'(done));
        check({tag, "_load_error"}, 32'(load_error), 32'(!done));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(!done));
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        // rx_valid held high in a terminal state must not consume bytes
        rx_data = 8'hA5;
        rx_valid = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        rx_valid = 1'b0;
        check({tag, "_held"}, 32'({load_done, load_error}), 32'({done, !done}));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_nwrites"}, 32'(writes_seen), 32'(n_writes));
    endtask

    logic [7:0] s1[$];
    logic [7:0] s[$];
    logic [31:0] w;

    initial begin
        reset = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        model_clear();
        s1 = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00, 8'h28};
        repeat (2) @(posedge clock);
        do_reset();
        check_reset_vals("rst");

        // 1: normal load
        send_stream(s1, 0);
        check_final("t1", 1'b1, 2);
        check("t1_mem0", mem_img[0], 32'h00100013);
        check("t1_mem1", mem_img[1], 32'h00200093);

        // 2: bad checksum
        do_reset();
        s = s1;
        s[10] = 8'h29;
        send_stream(s, 0);
        check_final("t2", 1'b0, 2);

        // 3: empty image
        do_reset();
        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 0);
        check_final("t3", 1'b1, 0);

        // 4a: oversize header is rejected right after its second byte
        do_reset();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        check_final("t4a", 1'b0, 0);

        // 4b: full-capacity image
        do_reset();
        s = '{8'h10, 8'h00};
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) s.push_back(w[8*k +: 8]);
        end
        begin
            logic [7:0] t;
            t = 8'h00;
            foreach (s[i]) t = t + s[i];
            s.push_back(8'h00 - t);
        end
        send_stream(s, 0);
        check_final("t4b", 1'b1, 16);
        check("t4b_last_addr", 32'(last_addr), 32'd15);

        // 5: random idle gaps
        do_reset();
        send_stream(s1, 5);
        check_final("t5", 1'b1, 2);
        check("t5_mem0", mem_img[0], 32'h00100013);
        check("t5_mem1", mem_img[1], 32'h00200093);

        // 6: reset after the 5th byte, then full replay
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(s1[i], 0);
        do_reset();
        check_reset_vals("t6_rst");
        for (int i = 0; i < 5; i++) send_byte(s1[i], 0);
        // reset coinciding with the word-completing byte suppresses the write
        rx_data = s1[5];
        rx_valid = 1'b1;
        do_reset();
        check_reset_vals("t6_rst2");
        send_stream(s1, 0);
        check_final("t6", 1'b1, 2);
        check("t6_mem0", mem_img[0], 32'h00100013);
        check("t6_mem1", mem_img[1], 32'h00200093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
